// File: rtl/outport_display.sv
// Output-port capture and multiplexed 7-segment scanner for the datapath's 32-bit output port.
// The displayed value changes only at frame boundaries, so a scan never mixes two values.
module outport_display #(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned LZB_EN       = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              OutWrite,
  input  logic [31:0]       OutData,
  input  logic              Run,
  output logic [7:0]        SegOut,
  output logic [DIGITS-1:0] DigitSel,
  output logic [31:0]       ShownValue,
  output logic              FrameTick
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned NIB_W = 4 * DIGITS;
  localparam int unsigned VAL_W = (NIB_W > 32) ? NIB_W : 32;

  logic [31:0]      pending;
  logic [CNT_W-1:0] slotCnt;
  logic [IDX_W-1:0] digitIdx;

  logic              slotEnd_c;
  logic              frameEnd_c;
  logic [VAL_W-1:0]  valExt_c;
  logic [DIGITS-1:0] leadZero_c;
  logic [3:0]        nibble_c;
  logic              digitBlank_c;
  logic [7:0]        segNext_c;
  logic [DIGITS-1:0] selNext_c;

  // Active-low {dp,g,f,e,d,c,b,a} pattern for one hex nibble, dp off.
  function automatic logic [7:0] hexSeg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign slotEnd_c  = (slotCnt == CNT_W'(REFRESH_DIV - 1));
  assign frameEnd_c = slotEnd_c && (digitIdx == IDX_W'(DIGITS - 1));

  // Nibbles past bit 31 read as zero when more than eight digits are scanned.
  assign valExt_c = VAL_W'(ShownValue);

  // leadZero_c[i] is set when nibble i and every nibble above it are zero.
  always_comb begin
    logic allZero;
    allZero    = 1'b1;
    leadZero_c = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      allZero       = allZero && (valExt_c[4*i +: 4] == 4'h0);
      leadZero_c[i] = allZero;
    end
  end

  // Select the nibble and blanking state of the digit currently being scanned.
  always_comb begin
    nibble_c     = 4'h0;
    digitBlank_c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (digitIdx == IDX_W'(i)) begin
        nibble_c     = valExt_c[4*i +: 4];
        digitBlank_c = (LZB_EN != 0) && (i > 0) && leadZero_c[i];
      end
    end
  end

  // Next anode/segment drive; the first slot cycles keep everything dark.
  always_comb begin
    segNext_c = 8'hFF;
    selNext_c = '1;
    if (slotCnt >= CNT_W'(BLANK_CYCLES)) begin
      selNext_c = ~(DIGITS'(1) << digitIdx);
      if (!digitBlank_c) begin
        segNext_c    = hexSeg(nibble_c);
        segNext_c[7] = !(Run && (digitIdx == IDX_W'(0)));
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pending    <= '0;
      ShownValue <= '0;
      slotCnt    <= '0;
      digitIdx   <= '0;
      SegOut     <= 8'hFF;
      DigitSel   <= '1;
      FrameTick  <= 1'b0;
    end else begin
      if (OutWrite) begin
        pending <= OutData;
      end
      if (slotEnd_c) begin
        slotCnt  <= '0;
        digitIdx <= frameEnd_c ? '0 : digitIdx + IDX_W'(1);
      end else begin
        slotCnt <= slotCnt + CNT_W'(1);
      end
      // A write landing on the boundary edge is committed directly.
      if (frameEnd_c) begin
        ShownValue <= OutWrite ? OutData : pending;
      end
      FrameTick <= frameEnd_c;
      SegOut    <= segNext_c;
      DigitSel  <= selNext_c;
    end
  end

endmodule

// File: tb/tb_outport_display.sv
// Bench for outport_display: table of display vectors checked over full scan frames,
// a commit scoreboard, plus boundary-write, back-to-back write and async reset sequences.
module tb_outport_display;

  logic        Clock;
  logic        Reset;
  logic        OutWrite;
  logic [31:0] OutData;
  logic        Run;
  logic [7:0]  SegOut, seg2;
  logic [7:0]  DigitSel, sel2;
  logic [31:0] ShownValue, shown2;
  logic        FrameTick, tick2;

  outport_display #(.DIGITS(8), .REFRESH_DIV(4), .BLANK_CYCLES(1), .LZB_EN(1)) dut (
    .Clock(Clock), .Reset(Reset), .OutWrite(OutWrite), .OutData(OutData), .Run(Run),
    .SegOut(SegOut), .DigitSel(DigitSel), .ShownValue(ShownValue), .FrameTick(FrameTick)
  );

  outport_display #(.DIGITS(8), .REFRESH_DIV(4), .BLANK_CYCLES(1), .LZB_EN(0)) dutNoLzb (
    .Clock(Clock), .Reset(Reset), .OutWrite(OutWrite), .OutData(OutData), .Run(Run),
    .SegOut(seg2), .DigitSel(sel2), .ShownValue(shown2), .FrameTick(tick2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] value;
    logic        run;
    logic [63:0] segs;   // expected SegOut per digit, digit 0 in [7:0]
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] sb [$];
  logic [31:0] lastShown;
  int          cmpCount;
  int          errCount;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmpCount++;
    if (act !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic writeVal(input logic [31:0] v, input logic r);
    OutData  = v;
    Run      = r;
    OutWrite = 1'b1;
    sb.delete();
    sb.push_back(v);
    @(negedge Clock);
    OutWrite = 1'b0;
  endtask

  // Wait (bounded) for FrameTick and check the committed value against the scoreboard.
  task automatic waitFrameTick();
    bit          seen;
    logic [31:0] exp;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge Clock);
      if (FrameTick) seen = 1'b1;
    end
    if (!seen) begin
      cmpCount++;
      errCount++;
      $display("FAIL frameTick timeout: got none expected pulse within 40 cycles");
    end else begin
      exp = lastShown;
      if (sb.size() > 0) exp = sb.pop_front();
      lastShown = exp;
      chk("shownValue commit", 64'(ShownValue), 64'(exp));
    end
  endtask

  // Starting at a FrameTick sample, check every slot of the following frame.
  task automatic checkFrame(input int vi);
    logic [7:0] exp;
    logic [7:0] exp2;
    logic [7:0] sel;
    for (int d = 0; d < 8; d++) begin
      exp  = vecs[vi].segs[8*d +: 8];
      exp2 = (d == 0 && vecs[vi].run) ? 8'h40 : 8'hC0;
      sel  = ~(8'h01 << d);
      for (int s = 0; s < 4; s++) begin
        @(negedge Clock);
        if (s == 0) begin
          chk($sformatf("v%0d blank sel d%0d", vi, d), 64'(DigitSel), 64'hFF);
          chk($sformatf("v%0d blank seg d%0d", vi, d), 64'(SegOut), 64'hFF);
        end else begin
          chk($sformatf("v%0d sel d%0d", vi, d), 64'(DigitSel), 64'(sel));
          chk($sformatf("v%0d seg d%0d", vi, d), 64'(SegOut), 64'(exp));
          if (vecs[vi].value == 32'h0) begin
            chk($sformatf("v%0d nolzb seg d%0d", vi, d), 64'(seg2), 64'(exp2));
            chk($sformatf("v%0d nolzb sel d%0d", vi, d), 64'(sel2), 64'(sel));
          end
        end
        if (s == 1) chk("frameTick idle", 64'(FrameTick), 64'h0);
      end
    end
    chk("frameTick end", 64'(FrameTick), 64'h1);
  endtask

  // Called at the negedge where Reset was released.
  task automatic startupChk();
    @(negedge Clock);
    chk("start blank sel", 64'(DigitSel), 64'hFF);
    chk("start blank seg", 64'(SegOut), 64'hFF);
    @(negedge Clock);
    chk("start sel d0", 64'(DigitSel), 64'hFE);
    chk("start seg d0", 64'(SegOut), 64'hC0);
    chk("start nolzb seg d0", 64'(seg2), 64'hC0);
    chk("start shown", 64'(ShownValue), 64'h0);
  endtask

  initial begin
    cmpCount  = 0;
    errCount  = 0;
    lastShown = 32'h0;
    Reset     = 1'b0;
    OutWrite  = 1'b0;
    OutData   = 32'h0;
    Run       = 1'b0;

    vecs[0] = '{32'h00000088, 1'b0, 64'hFFFFFFFF_FFFF8080};
    vecs[1] = '{32'hDEADBEEF, 1'b0, 64'hA18688A1_8386868E};
    vecs[2] = '{32'h00000005, 1'b1, 64'hFFFFFFFF_FFFFFF12};
    vecs[3] = '{32'h00000005, 1'b0, 64'hFFFFFFFF_FFFFFF92};
    vecs[4] = '{32'h00000000, 1'b0, 64'hFFFFFFFF_FFFFFFC0};
    vecs[5] = '{32'h00000000, 1'b1, 64'hFFFFFFFF_FFFFFF40};
    vecs[6] = '{32'h01234567, 1'b0, 64'hFFF9A4B0_999282F8};
    vecs[7] = '{32'h10000000, 1'b1, 64'hF9C0C0C0_C0C0C040};
    vecs[8] = '{32'h89ABC0DE, 1'b0, 64'h80908883_C6C0A186};

    repeat (3) @(negedge Clock);
    chk("reset seg", 64'(SegOut), 64'hFF);
    chk("reset sel", 64'(DigitSel), 64'hFF);
    chk("reset shown", 64'(ShownValue), 64'h0);
    chk("reset tick", 64'(FrameTick), 64'h0);
    Reset = 1'b1;
    startupChk();

    for (int i = 0; i < 9; i++) begin
      writeVal(vecs[i].value, vecs[i].run);
      chk($sformatf("v%0d hold", i), 64'(ShownValue), 64'(lastShown));
      waitFrameTick();
      checkFrame(i);
    end

    // Write on the boundary edge overrides the older pending value.
    writeVal(32'h00000001, 1'b0);
    repeat (30) @(negedge Clock);
    OutData  = 32'hDEADBEEF;
    OutWrite = 1'b1;
    sb.delete();
    sb.push_back(32'hDEADBEEF);
    @(negedge Clock);
    OutWrite = 1'b0;
    chk("boundary tick", 64'(FrameTick), 64'h1);
    chk("boundary shown", 64'(ShownValue), 64'hDEADBEEF);
    lastShown = 32'hDEADBEEF;
    sb.delete();
    checkFrame(1);

    // Back-to-back writes: only the last survives.
    OutData  = 32'hAAAA5555;
    OutWrite = 1'b1;
    @(negedge Clock);
    OutData  = 32'h00000003;
    sb.delete();
    sb.push_back(32'h00000003);
    @(negedge Clock);
    OutWrite = 1'b0;
    waitFrameTick();

    // Asynchronous reset between edges with an uncommitted pending value.
    writeVal(32'h00001234, 1'b0);
    repeat (2) @(negedge Clock);
    chk("pre-reset sel", 64'(DigitSel), 64'hFE);
    chk("pre-reset seg", 64'(SegOut), 64'hB0);
    #3 Reset = 1'b0;
    #1;
    chk("async seg", 64'(SegOut), 64'hFF);
    chk("async sel", 64'(DigitSel), 64'hFF);
    chk("async shown", 64'(ShownValue), 64'h0);
    repeat (2) @(negedge Clock);
    chk("async hold tick", 64'(FrameTick), 64'h0);
    Reset = 1'b1;
    sb.delete();
    lastShown = 32'h0;
    startupChk();
    waitFrameTick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule

// File: doc/outport_display.md
Name: outport_display

Overview:
- Downstream consumer of the datapath's 32-bit output port; drives the board's multiplexed 7-segment display.
- Captures a value on each output-port write and shows it as 8 hex digits.
- Scans one digit at a time, with a frame-synchronous display update (no tearing), optional leading-zero blanking, a run-status decimal point and anti-ghosting blank time.

Parameters:
- DIGITS, 8, number of scanned digits; each digit shows one nibble, digit 0 = OutData[3:0].
- REFRESH_DIV, 50000, clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- LZB_EN, 1, 1 = blank leading zero digits; digit 0 is never blanked.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- OutWrite  in  1  one-cycle strobe; datapath output port write.
- OutData  in  32  value written to the output port.
- Run  in  1  processor run status; lights the decimal point of digit 0.
- SegOut  out  8  active-low segments, bit order {dp,g,f,e,d,c,b,a}.
- DigitSel  out  DIGITS  active-low anode enables; one-hot-low or all ones.
- ShownValue  out  32  value currently being displayed.
- FrameTick  out  1  one-cycle pulse when a scan frame completes.

Behaviour:
- Reset (asynchronous, Reset=0):
  - pending=0, ShownValue=0, slot counter=0, digit index=0.
  - SegOut=8'hFF, DigitSel=all ones, FrameTick=0.
  - Reset asserted mid-frame abandons the frame; no partial commit.
- Capture: on an edge with OutWrite=1, pending <= OutData. Back-to-back writes keep only the last value.
- Slot counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - At terminal count the digit index advances mod DIGITS.
- Frame boundary (terminal count with index = DIGITS-1):
  - ShownValue <= (OutWrite ? OutData : pending); a write on this edge wins.
  - FrameTick=1 for exactly the following cycle.
- Outputs:
  - SegOut and DigitSel are registered.
  - Both reflect the index/counter state of the previous cycle (latency 1).
- Slot blanking:
  - While counter < BLANK_CYCLES (as seen through the latency-1 register), DigitSel=all ones and SegOut=8'hFF.
  - Otherwise DigitSel bit [index]=0 and all other bits are 1.
- Nibble: digit i shows ShownValue[4i+3:4i].
- Decode (active-low, dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8.
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- Leading-zero blanking (LZB_EN=1): digit i>0 shows SegOut=8'hFF (anode still driven) if every nibble at index >= i is zero.
- Decimal point: on digit 0, bit 7 of SegOut is cleared when Run=1. Run is sampled the same cycle as the index (latency 1). A blanked digit never lights dp.
- Value 0 shows a single "0" on digit 0 with LZB_EN=1.
- Width rule: nibbles beyond bit 31 (DIGITS > 8) read as zero.

Test Plan:
- Use DIGITS=8, REFRESH_DIV=4, BLANK_CYCLES=1, LZB_EN=1 unless stated.
- Reset: hold Reset=0 → SegOut=8'hFF, DigitSel=8'hFF, ShownValue=0. Release → first lit slot is digit 0 showing C0 (Run=0).
- Frame commit: OutWrite with OutData=32'h00000088 mid-frame. ShownValue stays 0 until the frame boundary, then becomes 32'h00000088 with FrameTick pulsing 1 cycle. Next frame: digits 0,1 → 80; digits 2..7 → FF with anodes 0..7 still scanned.
- Write at boundary: OutWrite on the same edge as the frame-boundary terminal count, with pending=32'h1 and OutData=32'hDEADBEEF → ShownValue=32'hDEADBEEF. Digit 7 shows A1 ("d"); digit 0 shows 8E ("F").
- Run dp: ShownValue=32'h5, Run=1 → digit 0 SegOut=8'h12; Run=0 → 8'h92. Other digits always have bit 7=1.
- Blanking/scan timing: each slot is 4 cycles with the first showing DigitSel=FF. DigitSel sequence: FE, FD, FB, … 7F, then wraps back to FE. LZB_EN=0 with value 0 → all digits show C0.
- Async reset mid-frame: pull Reset low between edges with pending=32'h1234 uncommitted → outputs go to FF immediately (not on the next edge). After release, ShownValue=0 and the digit index restarts at 0.
